reg_bank_write_arbiter: RTL



---
 rtl/reg_bank_write_arbiter_pkg.sv | 20 ++
 rtl/reg_bank_write_arbiter_rr_picker.sv | 31 +++
 rtl/reg_bank_write_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/reg_bank_write_arbiter_pkg.sv
// Shared state encoding, default widths and pointer helper for the register-bank write arbiter.
package reg_bank_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    localparam int DEF_NREQ   = 4;
    localparam int DEF_NREGS  = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_WIDTH  = 32;

    function automatic int next_ptr(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/reg_bank_write_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first set request at or after ptr_i, wrapping to 0.
module rr_picker
    import reg_bank_write_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDX_W = $clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        int cand;
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        for (int off = 0; off < NREQ; off++) begin
            cand = (int'(ptr_i) + off) % NREQ;
            if (!valid_o && req_i[cand]) begin
                valid_o        = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Arbitrates NREQ writers onto one register bank: IDLE -> GRANT -> WRITE -> DONE, all outputs registered.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; default build is round-robin.
module reg_bank_write_arbiter
    import reg_bank_write_arbiter_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int NREGS  = DEF_NREGS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WIDTH  = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*ADDR_W-1:0]  addr_in,
    input  logic [NREQ*WIDTH-1:0]   data_in,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    err,
    output logic [NREGS-1:0]        reg_en,
    output logic [WIDTH-1:0]        reg_d,
    output logic                    busy
);

    localparam int IDX_W = $clog2(NREQ);

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
    logic              err_q, err_d, busy_q, busy_d;
    logic [NREGS-1:0]  reg_en_q, reg_en_d;
    logic [WIDTH-1:0]  reg_d_q, reg_d_d, data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [IDX_W-1:0]  pick_ptr, pick_idx;
    logic [NREQ-1:0]   pick_onehot;
    logic              pick_valid;
    logic              addr_bad;

    assign addr_bad = (int'(addr_q) >= NREGS);

`ifdef ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IDX_W-1:0] rr_q, rr_d;

    // Pointer advances past the winner while entering DONE so the next IDLE already sees it.
    always_comb begin
        rr_d = rr_q;
        if (state_q == ST_WRITE) rr_d = IDX_W'(next_ptr(int'(idx_q), NREQ));
    end

    always_ff @(posedge clk) begin
        if (reset) rr_q <= '0;
        else       rr_q <= rr_d;
    end

    assign pick_ptr = rr_q;
`endif

    rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
        .req_i    (req),
        .ptr_i    (pick_ptr),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = 1'b0;
        reg_en_d = '0;
        reg_d_d  = reg_d_q;
        busy_d   = busy_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        data_d   = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick_onehot;
                    idx_d   = pick_idx;
                    addr_d  = addr_in[int'(pick_idx)*ADDR_W +: ADDR_W];
                    data_d  = data_in[int'(pick_idx)*WIDTH +: WIDTH];
                    reg_d_d = data_in[int'(pick_idx)*WIDTH +: WIDTH];
                    busy_d  = 1'b1;
                end
            end
            ST_GRANT: begin
                state_d = ST_WRITE;
                for (int r = 0; r < NREGS; r++) reg_en_d[r] = (int'(addr_q) == r);
            end
            ST_WRITE: begin
                state_d = ST_DONE;
                done_d  = gnt_q;
                err_d   = addr_bad;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            reg_en_q <= '0;
            reg_d_q  <= '0;
            busy_q   <= 1'b0;
            idx_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            reg_en_q <= reg_en_d;
            reg_d_q  <= reg_d_d;
            busy_q   <= busy_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign err    = err_q;
    assign reg_en = reg_en_q;
    assign reg_d  = reg_d_q;
    assign busy   = busy_q;

endmodule
